// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: runs a W-bit operation on a 4-bit ALU, one nibble per clock, LSB first.
module alu_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4*NIBBLES-1:0] req_a,
    input  logic [4*NIBBLES-1:0] req_b,
    input  logic [3:0]           req_opcode,
    input  logic                 req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*NIBBLES-1:0] rsp_out,
    output logic                 rsp_cout,
    output logic                 rsp_of,
    output logic                 rsp_zero,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [3:0]           alu_opcode,
    output logic                 alu_cin,
    input  logic [3:0]           alu_out,
    input  logic                 alu_cout,
    input  logic                 alu_of,
    input  logic                 alu_zero
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [IW-1:0] idx;
    logic [W-1:0]  a_r, b_r, result;
    logic [3:0]    op_r;
    logic          carry, zero_acc, cout_r, of_r, zero_r, last;

    assign last       = idx == IW'(NIBBLES - 1);
    assign rsp_out    = result;
    assign rsp_cout   = cout_r;
    assign rsp_of     = of_r;
    assign rsp_zero   = zero_r;
    assign alu_opcode = op_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = state == IDLE;
        rsp_valid = state == DONE;
        alu_a     = state == RUN ? a_r[idx*4 +: 4] : 4'd0;
        alu_b     = state == RUN ? b_r[idx*4 +: 4] : 4'd0;
        alu_cin   = state == RUN ? carry : 1'b0;
        if (state == IDLE && req_valid) state_nx = RUN;
        if (state == RUN && last)       state_nx = DONE;
        if (state == DONE && rsp_ready) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= '0;
            result   <= '0;
            carry    <= 1'b0;
            zero_acc <= 1'b0;
            cout_r   <= 1'b0;
            of_r     <= 1'b0;
            zero_r   <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            a_r      <= req_a;
            b_r      <= req_b;
            op_r     <= req_opcode;
            carry    <= req_cin;
            idx      <= '0;
            zero_acc <= 1'b1;
        end else if (state == RUN) begin
            result[idx*4 +: 4] <= alu_out;
            carry              <= alu_cout;
            zero_acc           <= zero_acc & alu_zero;
            idx                <= last ? '0 : idx + 1'b1;
            // Final nibble's flags become the response flags on the same edge.
            if (last) begin
                cout_r <= alu_cout;
                of_r   <= alu_of;
                zero_r <= zero_acc & alu_zero;
            end
        end
    end
endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: vectors, random ops vs W-bit reference, backpressure and reset corners.
module tb_alu_nibble_seq;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 0, rst_n = 0;
    logic         req_valid = 0, req_ready, req_cin = 0;
    logic [W-1:0] req_a = 0, req_b = 0, rsp_out;
    logic [3:0]   req_opcode = 0;
    logic         rsp_valid, rsp_ready = 0, rsp_cout, rsp_of, rsp_zero;
    logic [3:0]   alu_a, alu_b, alu_opcode, alu_out;
    logic         alu_cin, alu_cout, alu_of, alu_zero;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    alu_nibble_seq #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
        .rsp_cout(rsp_cout), .rsp_of(rsp_of), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_of(alu_of), .alu_zero(alu_zero)
    );

    // 4-bit ALU used by the controller: ADD=0, AND=1.
    always_comb begin
        logic [4:0] s;
        s        = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
        alu_out  = alu_opcode == 4'd1 ? (alu_a & alu_b) : s[3:0];
        alu_cout = alu_opcode == 4'd0 ? s[4] : 1'b0;
        alu_of   = alu_opcode == 4'd0 && alu_a[3] == alu_b[3] && s[3] != alu_a[3];
        alu_zero = alu_out == 4'd0;
    end

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic         cin;
        logic [W-1:0] out;
        logic         cout, of, zero;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Whole-word reference: plain W-bit arithmetic, no nibble slicing.
    function automatic vec_t model(input logic [3:0] op, input logic [W-1:0] a, b, input logic cin);
        vec_t v;
        logic [W:0] s;
        v.op = op; v.a = a; v.b = b; v.cin = cin;
        s = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
        if (op == 4'd0) begin
            v.out  = s[W-1:0];
            v.cout = s[W];
            v.of   = a[W-1] == b[W-1] && s[W-1] != a[W-1];
        end else begin
            v.out  = a & b;
            v.cout = 0;
            v.of   = 0;
        end
        v.zero = v.out == 0;
        return v;
    endfunction

    task automatic issue(input vec_t v);
        @(negedge clk);
        req_a = v.a; req_b = v.b; req_opcode = v.op; req_cin = v.cin; req_valid = 1;
        check("req_ready_idle", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    task automatic run_op(input vec_t v);
        int n;
        issue(v);
        @(negedge clk);
        check("alu_a_first", alu_a, v.a[3:0]);
        check("alu_b_first", alu_b, v.b[3:0]);
        check("alu_cin_first", alu_cin, v.cin);
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, N + 1);
        check("rsp_out", rsp_out, v.out);
        check("rsp_cout", rsp_cout, v.cout);
        check("rsp_of", rsp_of, v.of);
        check("rsp_zero", rsp_zero, v.zero);
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        check("rsp_valid_drop", rsp_valid, 0);
    endtask

    vec_t vecs[6];
    vec_t v, v2;

    initial begin
        vecs[0] = '{4'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{4'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{4'd0, 16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'd1, 16'hF0F0, 16'h0F0F, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{4'd0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp", {rsp_out, rsp_cout, rsp_of, rsp_zero}, 0);
        check("rst_alu", {alu_a, alu_b, alu_opcode, alu_cin}, 0);
        rst_n = 1;

        foreach (vecs[i]) run_op(vecs[i]);

        for (int i = 0; i < 30; i++)
            run_op(model(4'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom)));

        // Backpressure: hold DONE three cycles while a second request waits.
        v  = model(4'd0, 16'h1234, 16'h4321, 1'b1);
        v2 = model(4'd1, 16'hABCD, 16'hFF0F, 1'b0);
        issue(v);
        repeat (N) @(posedge clk);
        req_a = v2.a; req_b = v2.b; req_opcode = v2.op; req_cin = v2.cin; req_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_out", rsp_out, v.out);
            check("bp_flags", {rsp_cout, rsp_of, rsp_zero}, {v.cout, v.of, v.zero});
            check("bp_ready", req_ready, 0);
        end
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        check("bp_idle_ready", req_ready, 1);
        check("bp_idle_valid", rsp_valid, 0);
        @(posedge clk);
        #1 req_valid = 0;
        repeat (N) @(posedge clk);
        @(negedge clk);
        check("bp_second_valid", rsp_valid, 1);
        check("bp_second_out", rsp_out, v2.out);
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;

        // Reset while RUN is on nibble 2.
        v = model(4'd1, 16'h5A5A, 16'h3C3C, 1'b1);
        issue(v);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_alu_a", alu_a, v.a[11:8]);
        rst_n = 0;
        #1;
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_alu", {alu_a, alu_b, alu_opcode, alu_cin}, 0);
        @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mid_no_rsp", rsp_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Multi-cycle controller that runs NIBBLES*4-bit operations on the team's single 4-bit combinational ALU, one nibble per clock, least-significant nibble first.
- Carry is chained between nibbles. Overall flags are built from the nibble flags.
- Sits between a valid/ready request source and the ALU instance. It owns the ALU's a/b/opcode/cin inputs.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 2..8.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  controller can accept a request.
- req_a  in  W  operand A.
- req_b  in  W  operand B.
- req_opcode  in  4  ALU opcode, applied unchanged to every nibble.
- req_cin  in  1  carry-in for nibble 0.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_out  out  W  assembled result.
- rsp_cout  out  1  carry-out of the top nibble.
- rsp_of  out  1  overflow flag of the top nibble.
- rsp_zero  out  1  1 when every nibble zero flag was 1.
- alu_a  out  4  to ALU a.
- alu_b  out  4  to ALU b.
- alu_opcode  out  4  to ALU opcode.
- alu_cin  out  1  to ALU cin.
- alu_out  in  4  from ALU result.
- alu_cout  in  1  from ALU carry-out.
- alu_of  in  1  from ALU overflow.
- alu_zero  in  1  from ALU zero flag.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (rst_n low, asynchronous):
  - state=IDLE, idx=0.
  - All latched operands, result, carry and flags cleared.
  - req_ready=1, rsp_valid=0, rsp_* = 0, alu_* = 0.
- IDLE:
  - req_ready=1. alu_a/alu_b/alu_cin driven 0; alu_opcode = latched opcode.
  - On req_valid, at posedge: latch a, b, opcode; carry=req_cin; idx=0; zero_acc=1; go to RUN.
- RUN:
  - req_ready=0.
  - ALU inputs are driven combinationally from registers: alu_a=A[4*idx+:4], alu_b=B[4*idx+:4], alu_opcode=opcode, alu_cin=carry.
  - Each posedge: result[4*idx+:4]<=alu_out; carry<=alu_cout; zero_acc<=zero_acc&alu_zero; idx<=idx+1.
  - When idx==NIBBLES-1, on that same edge: rsp_cout<=alu_cout, rsp_of<=alu_of, rsp_zero<=zero_acc&alu_zero, go to DONE.
- DONE:
  - rsp_valid=1; rsp_* held stable; req_ready=0; alu_a/b/cin driven 0.
  - On rsp_ready at posedge: go to IDLE.
  - rsp_out keeps its last value after handshake. Downstream must qualify it with rsp_valid.
- Latency and throughput:
  - Request accepted at edge E; rsp_valid rises after edge E+NIBBLES.
  - Minimum issue interval is NIBBLES+2 cycles; there is no accept in the same cycle as DONE exit.
- Simultaneous events:
  - req_valid while in RUN/DONE is ignored; the requester holds it.
  - rsp_ready while not in DONE has no effect.
- Carry chain: the opcode does not affect chaining. Logical ops still propagate whatever alu_cout the ALU reports.
- Reset mid-operation (RUN or DONE): the operation is dropped, no rsp_valid pulse, back to IDLE immediately.
- idx width is clog2(NIBBLES); idx never exceeds NIBBLES-1.

Test Plan:
- Bench ALU model: ADD=4'b0000 (a+b+cin, OF=signed overflow); AND=4'b0001 (cout=0, OF=0). Default NIBBLES=4.
- ADD 0x00FF+0x0001, cin=0:
  - Cycle 1 drives alu_a=F, alu_b=1, alu_cin=0.
  - Response: rsp_out=0x0100, cout=0, of=0, zero=0.
  - rsp_valid 4 cycles after accept.
- ADD 0xFFFF+0x0001, cin=0: rsp_out=0x0000, cout=1, of=0, zero=1.
- ADD 0x7FFF+0x0001: rsp_out=0x8000, cout=0, of=1, zero=0.
- Mixed cases:
  - ADD 0x000F+0x0000 with cin=1 -> rsp_out=0x0010.
  - AND 0xF0F0&0x0F0F -> rsp_out=0x0000, zero=1.
- Backpressure and reset:
  - Hold rsp_ready=0 for 3 cycles in DONE: rsp_valid and rsp_* stable; req_ready=0; a second req_valid is not accepted until after the handshake.
  - rst_n low during RUN idx=2: immediately req_ready=1, rsp_valid=0, alu_* = 0; no response is ever produced.
